// File: rtl/soc_rst_pkg.sv
// -----------------------------------------------------------------------------
// soc_rst_pkg
// Shared definitions for the SoC reset sequencer.
//   rst_state_e     : sequencer state, encoding visible on state_o for debug
//   SOC_RST_MAX_DOM : largest supported number of sequenced reset domains
// -----------------------------------------------------------------------------
package soc_rst_pkg;

   localparam int SOC_RST_MAX_DOM = 16;

   typedef enum logic [2:0] {
      RST_RESET     = 3'd0,
      RST_LOCK_WAIT = 3'd1,
      RST_MEM_INIT  = 3'd2,
      RST_RELEASE   = 3'd3,
      RST_RUN       = 3'd4
   } rst_state_e;

endpackage

// File: rtl/rst_pulse_stretch.sv
// -----------------------------------------------------------------------------
// rst_pulse_stretch
// Software reset logic for one domain while the sequencer is in RUN. A request
// asserts the domain reset on the next edge. The reset is held for at least
// MIN_PULSE cycles and for as long as the request stays high.
// The domain reset flop lives in the parent; this block only proposes its next
// value and keeps the minimum-pulse counter.
// Ports:
//   clk_i    : clock
//   srst_i   : synchronous active-high reset
//   run_i    : sequencer stays in RUN across this edge; low clears the counter
//   req_i    : software reset request level for this domain
//   rst_q_i  : current registered domain reset
//   rst_d_o  : next domain reset value, valid while run_i is high
// -----------------------------------------------------------------------------
module rst_pulse_stretch #(
   parameter int MIN_PULSE = 8
) (
   input  logic clk_i,
   input  logic srst_i,
   input  logic run_i,
   input  logic req_i,
   input  logic rst_q_i,
   output logic rst_d_o
);

   localparam int CNT_W = $clog2(MIN_PULSE + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             min_met;

   // The counter holds the number of cycles the reset has been asserted,
   // saturating at MIN_PULSE.
   assign min_met = (cnt_q >= CNT_W'(MIN_PULSE));

   always_comb begin
      cnt_d   = cnt_q;
      rst_d_o = rst_q_i;
      if (!run_i) begin
         cnt_d = '0;
      end else if (!rst_q_i) begin
         // Asserting edge counts as the first cycle of the pulse.
         rst_d_o = req_i;
         cnt_d   = req_i ? CNT_W'(1) : '0;
      end else if (min_met && !req_i) begin
         rst_d_o = 1'b0;
      end else if (!min_met) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/soc_rst_sequencer.sv
// -----------------------------------------------------------------------------
// soc_rst_sequencer
// SoC reset sequencer: filters PLL lock, releases the memory controller and
// waits for calibration (with timeout), then releases N_DOM reset domains in
// order with RELEASE_GAP spacing. In RUN, software may pulse individual
// domains or restart the whole release sequence.
// Ports:
//   soc_clk       : sole clock
//   sys_rst       : synchronous active-high reset
//   pll_locked_i  : PLL lock (synchronised)
//   calib_done_i  : memory calibration done (synchronised)
//   sw_rst_req_i  : per-domain software reset request levels
//   sw_rst_all_i  : pulse restarting the domain release sequence
//   mem_rst_o     : memory controller reset, active high
//   dom_rst_o     : domain resets, active high
//   seq_done_o    : high in RUN
//   timeout_o     : sticky calibration timeout flag
//   state_o       : current state encoding
// -----------------------------------------------------------------------------
module soc_rst_sequencer
   import soc_rst_pkg::*;
#(
   parameter int N_DOM         = 4,
   parameter int LOCK_FILT     = 16,
   parameter int RELEASE_GAP   = 64,
   parameter int CALIB_TIMEOUT = 1048576,
   parameter int MIN_PULSE     = 8
) (
   input  logic             soc_clk,
   input  logic             sys_rst,
   input  logic             pll_locked_i,
   input  logic             calib_done_i,
   input  logic [N_DOM-1:0] sw_rst_req_i,
   input  logic             sw_rst_all_i,
   output logic             mem_rst_o,
   output logic [N_DOM-1:0] dom_rst_o,
   output logic             seq_done_o,
   output logic             timeout_o,
   output logic [2:0]       state_o
);

   localparam int FILT_W  = $clog2(LOCK_FILT + 1);
   // Gap and calibration wait never run at the same time, so they share one
   // counter sized for the larger of the two.
   localparam int CNT_MAX = (RELEASE_GAP > CALIB_TIMEOUT) ? RELEASE_GAP : CALIB_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   // Index sized for the largest supported domain count.
   localparam int IDX_W   = $clog2(SOC_RST_MAX_DOM);

   rst_state_e       state_q;
   logic [FILT_W-1:0] filt_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [IDX_W-1:0]  idx_q;
   logic              mem_rst_q;
   logic [N_DOM-1:0]  dom_rst_q;
   logic              seq_done_q;
   logic              timeout_q;

   logic              lock_lost;
   logic              restart_all;
   logic              run_keep;
   logic [N_DOM-1:0]  dom_run_d;

   // Lock loss outranks every other event; a restart only applies once the
   // memory controller is up.
   assign lock_lost   = !pll_locked_i &&
                        ((state_q == RST_MEM_INIT) || (state_q == RST_RELEASE) ||
                         (state_q == RST_RUN));
   assign restart_all = sw_rst_all_i &&
                        ((state_q == RST_RELEASE) || (state_q == RST_RUN));
   // Stretchers only act on edges where RUN is kept; leaving RUN clears them.
   assign run_keep    = (state_q == RST_RUN) && !lock_lost && !restart_all;

   for (genvar gi = 0; gi < N_DOM; gi++) begin : g_dom
      rst_pulse_stretch #(
         .MIN_PULSE (MIN_PULSE)
      ) u_stretch (
         .clk_i   (soc_clk),
         .srst_i  (sys_rst),
         .run_i   (run_keep),
         .req_i   (sw_rst_req_i[gi]),
         .rst_q_i (dom_rst_q[gi]),
         .rst_d_o (dom_run_d[gi])
      );
   end

   always_ff @(posedge soc_clk) begin
      if (sys_rst) begin
         state_q    <= RST_RESET;
         filt_q     <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         mem_rst_q  <= 1'b1;
         dom_rst_q  <= '1;
         seq_done_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else if (lock_lost) begin
         state_q    <= RST_LOCK_WAIT;
         filt_q     <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         mem_rst_q  <= 1'b1;
         dom_rst_q  <= '1;
         seq_done_q <= 1'b0;
      end else if (restart_all) begin
         // Also wins over a release landing on this same edge.
         state_q    <= RST_RELEASE;
         cnt_q      <= '0;
         idx_q      <= '0;
         dom_rst_q  <= '1;
         seq_done_q <= 1'b0;
      end else begin
         case (state_q)
            RST_RESET: begin
               state_q <= RST_LOCK_WAIT;
               filt_q  <= '0;
            end
            RST_LOCK_WAIT: begin
               // Lock is accepted on the sample after the filter is full.
               if (!pll_locked_i) begin
                  filt_q <= '0;
               end else if (filt_q == FILT_W'(LOCK_FILT)) begin
                  state_q   <= RST_MEM_INIT;
                  mem_rst_q <= 1'b0;
                  cnt_q     <= '0;
               end else begin
                  filt_q <= filt_q + FILT_W'(1);
               end
            end
            RST_MEM_INIT: begin
               if (calib_done_i) begin
                  state_q <= RST_RELEASE;
                  cnt_q   <= '0;
                  idx_q   <= '0;
               end else if (cnt_q == CNT_W'(CALIB_TIMEOUT - 1)) begin
                  timeout_q <= 1'b1;
                  state_q   <= RST_RELEASE;
                  cnt_q     <= '0;
                  idx_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RST_RELEASE: begin
               if (cnt_q == CNT_W'(RELEASE_GAP - 1)) begin
                  cnt_q            <= '0;
                  dom_rst_q[idx_q] <= 1'b0;
                  if (idx_q == IDX_W'(N_DOM - 1)) begin
                     state_q    <= RST_RUN;
                     seq_done_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RST_RUN: begin
               dom_rst_q <= dom_run_d;
            end
            default: begin
               // Unused encodings recover through a full restart.
               state_q    <= RST_RESET;
               filt_q     <= '0;
               cnt_q      <= '0;
               idx_q      <= '0;
               mem_rst_q  <= 1'b1;
               dom_rst_q  <= '1;
               seq_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_rst_o  = mem_rst_q;
   assign dom_rst_o  = dom_rst_q;
   assign seq_done_o = seq_done_q;
   assign timeout_o  = timeout_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_soc_rst_sequencer.sv
module tb_soc_rst_sequencer;

   localparam int N  = 4;
   localparam int F  = 16;
   localparam int G  = 64;
   localparam int T  = 100;
   localparam int M  = 8;

   logic         soc_clk = 1'b0;
   logic         sys_rst;
   logic         pll_locked;
   logic         calib_done;
   logic [N-1:0] sw_req;
   logic         sw_all;
   logic         mem_rst;
   logic [N-1:0] dom_rst;
   logic         seq_done;
   logic         timeout;
   logic [2:0]   state;

   int errors = 0;
   int checks = 0;

   always #5 soc_clk = ~soc_clk;

   soc_rst_sequencer #(
      .N_DOM         (N),
      .LOCK_FILT     (F),
      .RELEASE_GAP   (G),
      .CALIB_TIMEOUT (T),
      .MIN_PULSE     (M)
   ) dut (
      .soc_clk      (soc_clk),
      .sys_rst      (sys_rst),
      .pll_locked_i (pll_locked),
      .calib_done_i (calib_done),
      .sw_rst_req_i (sw_req),
      .sw_rst_all_i (sw_all),
      .mem_rst_o    (mem_rst),
      .dom_rst_o    (dom_rst),
      .seq_done_o   (seq_done),
      .timeout_o    (timeout),
      .state_o      (state)
   );

   // ---------------- reference model ----------------
   // Phase numbers follow the documented state_o encoding. Time in a phase is
   // kept as a plain elapsed-cycle count; outputs are derived from it.
   int         m_st = 0;
   int         m_run = 0;       // consecutive lock samples in LOCK_WAIT
   int         m_t = 0;         // cycles elapsed in MEM_INIT / RELEASE
   bit         m_to = 0;
   bit [N-1:0] m_act = '0;      // software-held domain resets in RUN
   int         m_at[N];         // cycle each software pulse began
   int         cyc = 0;

   task automatic model_step();
      cyc++;
      if (sys_rst) begin
         m_st = 0; m_to = 0; m_act = '0; m_run = 0; m_t = 0;
      end else if (m_st >= 2 && !pll_locked) begin
         m_st = 1; m_run = 0; m_act = '0;
      end else begin
         case (m_st)
            0: begin m_st = 1; m_run = 0; end
            1: begin
               if (!pll_locked) m_run = 0;
               else begin
                  m_run++;
                  if (m_run == F + 1) begin m_st = 2; m_t = 0; end
               end
            end
            2: begin
               m_t++;
               if (calib_done) begin m_st = 3; m_t = 0; end
               else if (m_t == T) begin m_to = 1; m_st = 3; m_t = 0; end
            end
            3: begin
               if (sw_all) m_t = 0;
               else begin
                  m_t++;
                  if (m_t == N * G) begin m_st = 4; m_act = '0; end
               end
            end
            default: begin
               if (sw_all) begin m_st = 3; m_t = 0; m_act = '0; end
               else begin
                  for (int k = 0; k < N; k++) begin
                     if (!m_act[k]) begin
                        if (sw_req[k]) begin m_act[k] = 1'b1; m_at[k] = cyc; end
                     end else if ((cyc - m_at[k]) >= M && !sw_req[k]) begin
                        m_act[k] = 1'b0;
                     end
                  end
               end
            end
         endcase
      end
   endtask

   function automatic logic [9:0] pk(bit mem, bit [N-1:0] dom, bit seq, bit to, bit [2:0] st);
      return {mem, dom, seq, to, st};
   endfunction

   function automatic logic [9:0] model_exp();
      logic [N-1:0] d;
      if (m_st <= 2)      d = '1;
      else if (m_st == 3) d = 4'hF << (m_t / G);
      else                d = m_act;
      return pk(m_st < 2, d, m_st == 4, m_to, 3'(m_st));
   endfunction

   function automatic logic [9:0] actual();
      return {mem_rst, dom_rst, seq_done, timeout, state};
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // One clock edge: advance the model, then compare every output against it.
   task automatic tick();
      @(posedge soc_clk);
      model_step();
      #1;
      check($sformatf("model cyc=%0d", cyc), int'(actual()), int'(model_exp()));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit         rst;
      bit         lock;
      bit         calib;
      bit         all;
      bit [N-1:0] req;
      int         n;
      logic [9:0] exp;   // {mem, dom, seq, timeout, state}
   } vec_t;

   vec_t vecs[$];

   function automatic void add(bit rst, bit lock, bit calib, bit all, bit [N-1:0] req, int n,
                               bit mem, bit [N-1:0] dom, bit seq, bit to, bit [2:0] st);
      vec_t v;
      v.rst = rst; v.lock = lock; v.calib = calib; v.all = all; v.req = req; v.n = n;
      v.exp = pk(mem, dom, seq, to, st);
      vecs.push_back(v);
   endfunction

   initial begin
      int width;
      int ticks;
      bit others_ok;
      bit [N-1:0] rq;

      sys_rst = 1'b1; pll_locked = 1'b1; calib_done = 1'b0; sw_req = '0; sw_all = 1'b0;
      foreach (m_at[k]) m_at[k] = 0;

      //   rst lock cal all req  n      mem dom    seq to st
      // basic sequence, calibration 10 cycles into MEM_INIT
      add(1, 1, 0, 0, 4'h0, 3,    1, 4'hF, 0, 0, 3'd0);
      add(0, 1, 0, 0, 4'h0, 1,    1, 4'hF, 0, 0, 3'd1);
      add(0, 1, 0, 0, 4'h0, 16,   1, 4'hF, 0, 0, 3'd1);
      add(0, 1, 0, 0, 4'h0, 1,    0, 4'hF, 0, 0, 3'd2);
      add(0, 1, 0, 0, 4'h0, 9,    0, 4'hF, 0, 0, 3'd2);
      add(0, 1, 1, 0, 4'h0, 1,    0, 4'hF, 0, 0, 3'd3);
      add(0, 1, 1, 0, 4'h0, 63,   0, 4'hF, 0, 0, 3'd3);
      add(0, 1, 1, 0, 4'h0, 1,    0, 4'hE, 0, 0, 3'd3);
      add(0, 1, 1, 0, 4'h0, 63,   0, 4'hE, 0, 0, 3'd3);
      add(0, 1, 1, 0, 4'h0, 1,    0, 4'hC, 0, 0, 3'd3);
      add(0, 1, 1, 0, 4'h0, 63,   0, 4'hC, 0, 0, 3'd3);
      add(0, 1, 1, 0, 4'h0, 1,    0, 4'h8, 0, 0, 3'd3);
      add(0, 1, 1, 0, 4'h0, 63,   0, 4'h8, 0, 0, 3'd3);
      add(0, 1, 1, 0, 4'h0, 1,    0, 4'h0, 1, 0, 3'd4);
      add(0, 1, 1, 0, 4'h0, 10,   0, 4'h0, 1, 0, 3'd4);
      // lock loss in RUN, then a one-cycle glitch at filter count 10
      add(0, 0, 0, 0, 4'h0, 1,    1, 4'hF, 0, 0, 3'd1);
      add(0, 1, 0, 0, 4'h0, 10,   1, 4'hF, 0, 0, 3'd1);
      add(0, 0, 0, 0, 4'h0, 1,    1, 4'hF, 0, 0, 3'd1);
      add(0, 1, 0, 0, 4'h0, 16,   1, 4'hF, 0, 0, 3'd1);
      add(0, 1, 0, 0, 4'h0, 1,    0, 4'hF, 0, 0, 3'd2);
      // calibration timeout after 100 cycles in MEM_INIT
      add(0, 1, 0, 0, 4'h0, 99,   0, 4'hF, 0, 0, 3'd2);
      add(0, 1, 0, 0, 4'h0, 1,    0, 4'hF, 0, 1, 3'd3);
      add(0, 1, 0, 0, 4'h0, 256,  0, 4'h0, 1, 1, 3'd4);
      // restart from RUN, then lock loss after domain 1 released
      add(0, 1, 0, 1, 4'h0, 1,    0, 4'hF, 0, 1, 3'd3);
      add(0, 1, 0, 0, 4'h0, 64,   0, 4'hE, 0, 1, 3'd3);
      add(0, 1, 0, 0, 4'h0, 64,   0, 4'hC, 0, 1, 3'd3);
      add(0, 0, 0, 0, 4'h0, 1,    1, 4'hF, 0, 1, 3'd1);
      // relock; restart on the edge of the last release
      add(0, 1, 1, 0, 4'h0, 17,   0, 4'hF, 0, 1, 3'd2);
      add(0, 1, 1, 0, 4'h0, 1,    0, 4'hF, 0, 1, 3'd3);
      add(0, 1, 1, 0, 4'h0, 255,  0, 4'h8, 0, 1, 3'd3);
      add(0, 1, 1, 1, 4'h0, 1,    0, 4'hF, 0, 1, 3'd3);
      add(0, 1, 1, 0, 4'h0, 63,   0, 4'hF, 0, 1, 3'd3);
      add(0, 1, 1, 0, 4'h0, 1,    0, 4'hE, 0, 1, 3'd3);
      add(0, 1, 1, 0, 4'h0, 192,  0, 4'h0, 1, 1, 3'd4);
      // short request on domain 2 stretched to 8 cycles
      add(0, 1, 1, 0, 4'h4, 2,    0, 4'h4, 1, 1, 3'd4);
      add(0, 1, 1, 0, 4'h0, 5,    0, 4'h4, 1, 1, 3'd4);
      add(0, 1, 1, 0, 4'h0, 1,    0, 4'h4, 1, 1, 3'd4);
      add(0, 1, 1, 0, 4'h0, 1,    0, 4'h0, 1, 1, 3'd4);
      // long request on domain 0 released when the request drops
      add(0, 1, 1, 0, 4'h1, 12,   0, 4'h1, 1, 1, 3'd4);
      add(0, 1, 1, 0, 4'h0, 1,    0, 4'h0, 1, 1, 3'd4);

      foreach (vecs[i]) begin
         sys_rst = vecs[i].rst; pll_locked = vecs[i].lock; calib_done = vecs[i].calib;
         sw_all = vecs[i].all; sw_req = vecs[i].req;
         repeat (vecs[i].n) tick();
         check($sformatf("vec%0d", i), int'(actual()), int'(vecs[i].exp));
         $display("vec %0d: %0d cycles, outputs=0x%0h expected=0x%0h", i, vecs[i].n, actual(), vecs[i].exp);
      end

      // ---- hand sequence: one-cycle request on domain 3, measure width ----
      sw_req = 4'b1000; tick(); sw_req = '0;
      width = 0; others_ok = 1'b1;
      for (int i = 0; i < 40 && dom_rst[3]; i++) begin
         width++;
         if (dom_rst[2:0] != 3'b000) others_ok = 1'b0;
         tick();
      end
      check("pulse_width_dom3", width, M);
      check("pulse_others_quiet", int'(others_ok), 1);
      $display("pulse on dom3: width=%0d", width);

      // ---- hand sequence: sys_rst mid-operation clears the sticky flag ----
      check("timeout_before_rst", int'(timeout), 1);
      sys_rst = 1'b1; tick();
      check("mid_rst_outputs", int'(actual()), int'(pk(1, 4'hF, 0, 0, 3'd0)));
      $display("sys_rst mid-run: outputs=0x%0h", actual());

      // ---- hand sequence: seq_done latency from reset release ----
      sys_rst = 1'b0; pll_locked = 1'b1; calib_done = 1'b1;
      ticks = 0;
      for (int i = 0; i < 2000 && !seq_done; i++) begin
         tick();
         ticks++;
      end
      check("seq_done_latency", ticks, F + 2 + N * G + 1);
      $display("seq_done after %0d edges", ticks);

      // ---- randomised run against the reference model ----
      rq = '0;
      for (int i = 0; i < 20000; i++) begin
         sys_rst = ($urandom_range(0, 999) == 0);
         if (pll_locked) pll_locked = ($urandom_range(0, 499) != 0);
         else            pll_locked = ($urandom_range(0, 1) == 1);
         calib_done = ($urandom_range(0, 99) < 2);
         sw_all = ($urandom_range(0, 499) == 0);
         for (int k = 0; k < N; k++)
            if ($urandom_range(0, 15) == 0) rq[k] = ~rq[k];
         sw_req = rq;
         tick();
      end
      $display("random run: %0d cycles", 20000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
